// File: rtl/cpu_alu_flag_unit.sv
// Sequenced PIC10 ALU stage: captures operands, computes result and C/DC/Z flags,
// then presents one write-back cycle of STATUS load strobes.
module cpu_alu_flag_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] alu_op,
    input  logic [7:0] w_in,
    input  logic [7:0] f_in,
    input  logic [2:0] bit_sel,
    input  logic       carry_in,
    input  logic       dest_is_status,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] alu_to_status,
    output logic [2:0] status_bus,
    output logic       load_status_reg,
    output logic       status_c_load,
    output logic       status_dc_load,
    output logic       status_z_load
);

    localparam int unsigned STATUS_C  = 0;
    localparam int unsigned STATUS_DC = 1;
    localparam int unsigned STATUS_Z  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_IOR   = 4'd3,
        OP_XOR   = 4'd4,
        OP_COM   = 4'd5,
        OP_INC   = 4'd6,
        OP_DEC   = 4'd7,
        OP_MOVF  = 4'd8,
        OP_CLR   = 4'd9,
        OP_RLF   = 4'd10,
        OP_RRF   = 4'd11,
        OP_SWAP  = 4'd12,
        OP_BCF   = 4'd13,
        OP_BSF   = 4'd14,
        OP_PASSW = 4'd15
    } op_t;

    state_t     state_q, state_d;
    op_t        op_q;
    logic [7:0] a_q, w_q;
    logic [2:0] bit_q;
    logic       cin_q;
    logic       dst_q;
    logic [7:0] result_q, result_d;
    logic [2:0] flags_q, flags_d;
    logic [2:0] mask_q, mask_d;

    logic [8:0] sum9;
    logic [4:0] nib5;
    logic [7:0] bit_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            w_q      <= '0;
            bit_q    <= '0;
            cin_q    <= 1'b0;
            dst_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            mask_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                op_q  <= op_t'(alu_op);
                a_q   <= f_in;
                w_q   <= w_in;
                bit_q <= bit_sel;
                cin_q <= carry_in;
                dst_q <= dest_is_status;
            end
            if (state_q == EXEC) begin
                result_q <= result_d;
                flags_q  <= flags_d;
                mask_q   <= mask_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flags not written by the opcode stay 0 on the bus as well as on the strobes.
    always_comb begin
        sum9     = {1'b0, a_q} + {1'b0, w_q};
        nib5     = {1'b0, a_q[3:0]} + {1'b0, w_q[3:0]};
        bit_mask = 8'h01 << bit_q;
        result_d = '0;
        flags_d  = '0;
        mask_d   = '0;
        case (op_q)
            OP_ADD: begin
                result_d          = sum9[7:0];
                flags_d[STATUS_C]  = sum9[8];
                flags_d[STATUS_DC] = nib5[4];
                mask_d            = 3'b111;
            end
            OP_SUB: begin
                result_d          = a_q - w_q;
                flags_d[STATUS_C]  = (a_q >= w_q);
                flags_d[STATUS_DC] = (a_q[3:0] >= w_q[3:0]);
                mask_d            = 3'b111;
            end
            OP_AND:  begin result_d = a_q & w_q;   mask_d[STATUS_Z] = 1'b1; end
            OP_IOR:  begin result_d = a_q | w_q;   mask_d[STATUS_Z] = 1'b1; end
            OP_XOR:  begin result_d = a_q ^ w_q;   mask_d[STATUS_Z] = 1'b1; end
            OP_COM:  begin result_d = ~a_q;        mask_d[STATUS_Z] = 1'b1; end
            OP_INC:  begin result_d = a_q + 8'd1;  mask_d[STATUS_Z] = 1'b1; end
            OP_DEC:  begin result_d = a_q - 8'd1;  mask_d[STATUS_Z] = 1'b1; end
            OP_MOVF: begin result_d = a_q;         mask_d[STATUS_Z] = 1'b1; end
            OP_CLR:  begin result_d = 8'h00;       mask_d[STATUS_Z] = 1'b1; end
            OP_RLF: begin
                result_d         = {a_q[6:0], cin_q};
                flags_d[STATUS_C] = a_q[7];
                mask_d[STATUS_C]  = 1'b1;
            end
            OP_RRF: begin
                result_d         = {cin_q, a_q[7:1]};
                flags_d[STATUS_C] = a_q[0];
                mask_d[STATUS_C]  = 1'b1;
            end
            OP_SWAP:  result_d = {a_q[3:0], a_q[7:4]};
            OP_BCF:   result_d = a_q & ~bit_mask;
            OP_BSF:   result_d = a_q | bit_mask;
            OP_PASSW: result_d = w_q;
            default:  result_d = '0;
        endcase
        flags_d[STATUS_Z] = mask_d[STATUS_Z] & (result_d == 8'h00);
    end

    always_comb begin
        busy            = (state_q != IDLE);
        done            = (state_q == WB);
        result          = result_q;
        alu_to_status   = result_q;
        status_bus      = flags_q;
        load_status_reg = (state_q == WB) & dst_q;
        status_c_load   = (state_q == WB) & mask_q[STATUS_C];
        status_dc_load  = (state_q == WB) & mask_q[STATUS_DC];
        status_z_load   = (state_q == WB) & mask_q[STATUS_Z];
    end

endmodule

// File: tb/tb_cpu_alu_flag_unit.sv
// Directed self-checking bench for cpu_alu_flag_unit: hand-computed results,
// flags, strobe sets and handshake timing.
module tb_cpu_alu_flag_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] alu_op = '0;
    logic [7:0] w_in = '0;
    logic [7:0] f_in = '0;
    logic [2:0] bit_sel = '0;
    logic       carry_in = 1'b0;
    logic       dest_is_status = 1'b0;
    logic       busy, done, load_status_reg;
    logic       status_c_load, status_dc_load, status_z_load;
    logic [7:0] result, alu_to_status;
    logic [2:0] status_bus;

    int unsigned checks = 0;
    int unsigned failures = 0;

    cpu_alu_flag_unit dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .alu_op          (alu_op),
        .w_in            (w_in),
        .f_in            (f_in),
        .bit_sel         (bit_sel),
        .carry_in        (carry_in),
        .dest_is_status  (dest_is_status),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .alu_to_status   (alu_to_status),
        .status_bus      (status_bus),
        .load_status_reg (load_status_reg),
        .status_c_load   (status_c_load),
        .status_dc_load  (status_dc_load),
        .status_z_load   (status_z_load)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] strobes();
        return {status_z_load, status_dc_load, status_c_load};
    endfunction

    // Issues one op from IDLE and returns the WB snapshot; tbad flags any handshake deviation.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] w,
                          input logic [2:0] b, input logic c, input logic d,
                          output logic [7:0] res, output logic [7:0] ats,
                          output logic [2:0] bus, output logic [2:0] stb,
                          output logic lsr, output logic tbad);
        tbad = 1'b0;
        alu_op = op; f_in = a; w_in = w; bit_sel = b; carry_in = c; dest_is_status = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy !== 1'b1 || done !== 1'b0 || strobes() !== 3'b000 || load_status_reg !== 1'b0)
            tbad = 1'b1;
        @(posedge clk); #1;
        if (busy !== 1'b1 || done !== 1'b1) tbad = 1'b1;
        res = result; ats = alu_to_status; bus = status_bus; stb = strobes(); lsr = load_status_reg;
        @(posedge clk); #1;
        if (busy !== 1'b0 || done !== 1'b0 || strobes() !== 3'b000 || load_status_reg !== 1'b0)
            tbad = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, load_status_reg, strobes(), status_bus, result, alu_to_status} !== '0) begin
            failures++;
            $display("FAIL reset got busy=%b done=%b lsr=%b stb=%b bus=%b res=%h ats=%h exp all zero",
                     busy, done, load_status_reg, strobes(), status_bus, result, alu_to_status);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [7:0] r, t; logic [2:0] bus, stb; logic lsr, tb;
        run_op(4'd0, 8'h0F, 8'h01, 3'd0, 1'b0, 1'b0, r, t, bus, stb, lsr, tb);
        checks++;
        if ({r, t, bus, stb, lsr, tb} !== {8'h10, 8'h10, 3'b010, 3'b111, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add got res=%h ats=%h bus=%b stb=%b lsr=%b tbad=%b exp res=10 ats=10 bus=010 stb=111 lsr=0 tbad=0",
                     r, t, bus, stb, lsr, tb);
        end
    endtask

    task automatic test_sub();
        logic [7:0] r, t; logic [2:0] bus, stb; logic lsr, tb;
        run_op(4'd1, 8'h05, 8'h05, 3'd0, 1'b0, 1'b0, r, t, bus, stb, lsr, tb);
        checks++;
        if ({r, bus, stb, tb} !== {8'h00, 3'b111, 3'b111, 1'b0}) begin
            failures++;
            $display("FAIL sub_equal got res=%h bus=%b stb=%b tbad=%b exp res=00 bus=111 stb=111 tbad=0",
                     r, bus, stb, tb);
        end
        run_op(4'd1, 8'h03, 8'h05, 3'd0, 1'b0, 1'b0, r, t, bus, stb, lsr, tb);
        checks++;
        if ({r, bus, stb, tb} !== {8'hFE, 3'b000, 3'b111, 1'b0}) begin
            failures++;
            $display("FAIL sub_borrow got res=%h bus=%b stb=%b tbad=%b exp res=fe bus=000 stb=111 tbad=0",
                     r, bus, stb, tb);
        end
    endtask

    task automatic test_rlf();
        logic [7:0] r, t; logic [2:0] bus, stb; logic lsr, tb;
        run_op(4'd10, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0, r, t, bus, stb, lsr, tb);
        checks++;
        if ({r, bus, stb, tb} !== {8'h00, 3'b001, 3'b001, 1'b0}) begin
            failures++;
            $display("FAIL rlf got res=%h bus=%b stb=%b tbad=%b exp res=00 bus=001 stb=001 tbad=0",
                     r, bus, stb, tb);
        end
    endtask

    task automatic test_clr_status();
        logic [7:0] r, t; logic [2:0] bus, stb; logic lsr, tb;
        run_op(4'd9, 8'h5A, 8'h33, 3'd0, 1'b1, 1'b1, r, t, bus, stb, lsr, tb);
        checks++;
        if ({t, bus, stb, lsr, tb} !== {8'h00, 3'b100, 3'b100, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL clr_status got ats=%h bus=%b stb=%b lsr=%b tbad=%b exp ats=00 bus=100 stb=100 lsr=1 tbad=0",
                     t, bus, stb, lsr, tb);
        end
    endtask

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] w;
        logic [2:0] b;
        logic       c;
        logic [7:0] r;
        logic [2:0] bus;
        logic [2:0] stb;
    } vec_t;

    task automatic test_ops();
        vec_t vt[13];
        logic [7:0] r, t; logic [2:0] bus, stb; logic lsr, tb;
        vt[0]  = '{4'd2,  8'hF0, 8'h3C, 3'd0, 1'b0, 8'h30, 3'b000, 3'b100};
        vt[1]  = '{4'd3,  8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 3'b100, 3'b100};
        vt[2]  = '{4'd4,  8'hAA, 8'hAA, 3'd0, 1'b0, 8'h00, 3'b100, 3'b100};
        vt[3]  = '{4'd5,  8'h5A, 8'h00, 3'd0, 1'b0, 8'hA5, 3'b000, 3'b100};
        vt[4]  = '{4'd6,  8'hFF, 8'h00, 3'd0, 1'b0, 8'h00, 3'b100, 3'b100};
        vt[5]  = '{4'd7,  8'h00, 8'h00, 3'd0, 1'b0, 8'hFF, 3'b000, 3'b100};
        vt[6]  = '{4'd8,  8'h00, 8'h77, 3'd0, 1'b0, 8'h00, 3'b100, 3'b100};
        vt[7]  = '{4'd11, 8'h01, 8'h00, 3'd0, 1'b1, 8'h80, 3'b001, 3'b001};
        vt[8]  = '{4'd12, 8'hA5, 8'h00, 3'd0, 1'b0, 8'h5A, 3'b000, 3'b000};
        vt[9]  = '{4'd13, 8'hFF, 8'h00, 3'd3, 1'b0, 8'hF7, 3'b000, 3'b000};
        vt[10] = '{4'd15, 8'h00, 8'hC3, 3'd0, 1'b0, 8'hC3, 3'b000, 3'b000};
        vt[11] = '{4'd0,  8'hFF, 8'h01, 3'd0, 1'b0, 8'h00, 3'b111, 3'b111};
        vt[12] = '{4'd10, 8'h01, 8'h00, 3'd0, 1'b1, 8'h03, 3'b000, 3'b001};
        for (int i = 0; i < 13; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].w, vt[i].b, vt[i].c, 1'b0, r, t, bus, stb, lsr, tb);
            checks++;
            if ({r, t, bus, stb, lsr, tb} !== {vt[i].r, vt[i].r, vt[i].bus, vt[i].stb, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL op_table[%0d] op=%0d got res=%h ats=%h bus=%b stb=%b lsr=%b tbad=%b exp res=%h bus=%b stb=%b lsr=0 tbad=0",
                         i, vt[i].op, r, t, bus, stb, lsr, tb, vt[i].r, vt[i].bus, vt[i].stb);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int unsigned dones = 0;
        logic seen_idle = 1'b0;
        logic [2:0] stb_wb = '0;
        alu_op = 4'd14; f_in = 8'h00; w_in = 8'h00; bit_sel = 3'd7; carry_in = 1'b0; dest_is_status = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        alu_op = 4'd15; w_in = 8'h55;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin dones++; stb_wb = strobes(); end
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b0) seen_idle = 1'b1;
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || result !== 8'h80 || stb_wb !== 3'b000 || seen_idle !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore got dones=%0d res=%h stb=%b idle_seen=%b exp dones=1 res=80 stb=000 idle_seen=1",
                     dones, result, stb_wb, seen_idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat = '0;
        alu_op = 4'd6; f_in = 8'h10; w_in = 8'h00; bit_sel = 3'd0; carry_in = 1'b0; dest_is_status = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[5 - i] = done;
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pat !== 6'b010010 || result !== 8'h11) begin
            failures++;
            $display("FAIL back_to_back got done_pattern=%b res=%h exp done_pattern=010010 res=11", pat, result);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] r, t; logic [2:0] bus, stb; logic lsr, tb;
        logic quiet = 1'b1;
        alu_op = 4'd0; f_in = 8'h0F; w_in = 8'h01; bit_sel = 3'd0; carry_in = 1'b0; dest_is_status = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, done, load_status_reg, strobes(), result} !== '0) begin
            failures++;
            $display("FAIL reset_mid_op got busy=%b done=%b lsr=%b stb=%b res=%h exp all zero",
                     busy, done, load_status_reg, strobes(), result);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || strobes() !== 3'b000 || load_status_reg !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL reset_no_strobe got quiet=%b exp quiet=1", quiet);
        end
        run_op(4'd0, 8'h0F, 8'h01, 3'd0, 1'b0, 1'b0, r, t, bus, stb, lsr, tb);
        checks++;
        if ({r, bus, stb, lsr, tb} !== {8'h10, 3'b010, 3'b111, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL after_reset_op got res=%h bus=%b stb=%b lsr=%b tbad=%b exp res=10 bus=010 stb=111 lsr=0 tbad=0",
                     r, bus, stb, lsr, tb);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_rlf();
        test_clr_status();
        test_ops();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
